// File: rtl/el2_lsu_ecc_scrub.sv
// el2_lsu_ecc_scrub: N-bank SEC-DED check/correct for DCCM reads, plus a scrub write-back queue
// and saturating single/double/drop error counters for the TLU.
// Latency: decode results (sec_data, sec_err, ded_err, sec_cnt, ded_cnt) 1 cycle after rd_valid;
// queue push 1 cycle after detection; wb_ecc is combinational from the queue head.
// Backpressure: wb_valid/wb_ready. The head holds while not accepted; pushes that find no free
// slot are dropped (highest bank first) and counted in drop_cnt.
// Ports: rd_* raw bank reads in; sec_data/sec_err/ded_err/any_* registered decode results;
// wb_* scrub write-back port; *_cnt counters.
// Optional: `define LSU_ECC_ERR_INJECT_EN adds inj_mask/inj_bank/inj_arm one-shot error injection.
module el2_lsu_ecc_scrub #(
    parameter int NUM_BANKS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ECC_WIDTH  = 7,
    parameter int ADDR_WIDTH = 16,
    parameter int WBQ_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_BANKS-1:0]             rd_valid,
    input  logic [ADDR_WIDTH*NUM_BANKS-1:0]  rd_addr,
    input  logic [DATA_WIDTH*NUM_BANKS-1:0]  rd_data,
    input  logic [ECC_WIDTH*NUM_BANKS-1:0]   rd_ecc,
    input  logic                             ecc_disable,
    input  logic                             scrub_en,
    input  logic                             cnt_clr,
`ifdef LSU_ECC_ERR_INJECT_EN
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0]  inj_mask,
    input  logic [BW-1:0]                    inj_bank,
    input  logic                             inj_arm,
`endif
    output logic [DATA_WIDTH*NUM_BANKS-1:0]  sec_data,
    output logic [NUM_BANKS-1:0]             sec_err,
    output logic [NUM_BANKS-1:0]             ded_err,
    output logic                             any_sec,
    output logic                             any_ded,
    output logic                             wb_valid,
    input  logic                             wb_ready,
    output logic [ADDR_WIDTH-1:0]            wb_addr,
    output logic [BW-1:0]                    wb_bank,
    output logic [DATA_WIDTH-1:0]            wb_data,
    output logic [ECC_WIDTH-1:0]             wb_ecc,
    output logic [CNT_WIDTH-1:0]             sec_cnt,
    output logic [CNT_WIDTH-1:0]             ded_cnt,
    output logic [CNT_WIDTH-1:0]             drop_cnt
);

    localparam int K  = ECC_WIDTH - 1;          // Hamming check bits; MSB is overall parity
    localparam int CW = DATA_WIDTH + K;         // highest codeword position (positions start at 1)
    localparam int PW = $clog2(WBQ_DEPTH);
    localparam int QW = PW + 2;

    // Data bits fill the non-power-of-two codeword positions in ascending order.
    function automatic logic [ECC_WIDTH-1:0] hm_encode(input logic [DATA_WIDTH-1:0] d);
        logic [ECC_WIDTH-1:0] e;
        int di;
        e  = '0;
        di = 0;
        for (int p = 1; p <= CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                for (int j = 0; j < K; j++)
                    if (((p >> j) & 1) == 1) e[j] = e[j] ^ d[di];
                di++;
            end
        end
        e[K] = ^{d, e[K-1:0]};
        return e;
    endfunction

    // Data bit sitting at codeword position syn; all-zero when syn names a check bit or no bit.
    function automatic logic [DATA_WIDTH-1:0] flip_mask(input logic [K-1:0] syn);
        logic [DATA_WIDTH-1:0] m;
        int di;
        m  = '0;
        di = 0;
        for (int p = 1; p <= CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (p == int'(syn)) m[di] = 1'b1;
                di++;
            end
        end
        return m;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a, input logic [2:0] n);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(n);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    logic [NUM_BANKS-1:0]  chk, sec_det, ded_det;
    logic [DATA_WIDTH-1:0] cor_d  [NUM_BANKS];
    logic [DATA_WIDTH-1:0] sdat_q [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] addr_q [NUM_BANKS];
    logic [NUM_BANKS-1:0]  sec_q, ded_q, preq_q;

`ifdef LSU_ECC_ERR_INJECT_EN
    logic                            inj_armed_q;
    logic [DATA_WIDTH+ECC_WIDTH-1:0] inj_mask_q;
    logic [BW-1:0]                   inj_bank_q;
    logic                            inj_hit;

    assign inj_hit = inj_armed_q & chk[inj_bank_q];

    // A fresh arm always wins, so re-arming reloads the mask even in the cycle it would fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_armed_q <= 1'b0;
            inj_mask_q  <= '0;
            inj_bank_q  <= '0;
        end else if (inj_arm) begin
            inj_armed_q <= 1'b1;
            inj_mask_q  <= inj_mask;
            inj_bank_q  <= inj_bank;
        end else if (inj_hit) begin
            inj_armed_q <= 1'b0;
        end
    end
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] raw_d;
        logic [ECC_WIDTH-1:0]  raw_e, enc;
        logic [K-1:0]          syn;
        logic                  par;

`ifdef LSU_ECC_ERR_INJECT_EN
        assign {raw_e, raw_d} = {rd_ecc[b*ECC_WIDTH +: ECC_WIDTH], rd_data[b*DATA_WIDTH +: DATA_WIDTH]}
                              ^ ((inj_armed_q && (inj_bank_q == BW'(b))) ? inj_mask_q : '0);
`else
        assign raw_d = rd_data[b*DATA_WIDTH +: DATA_WIDTH];
        assign raw_e = rd_ecc[b*ECC_WIDTH +: ECC_WIDTH];
`endif
        assign enc        = hm_encode(raw_d);
        assign syn        = raw_e[K-1:0] ^ enc[K-1:0];
        assign par        = ^{raw_e, raw_d};
        assign chk[b]     = rd_valid[b] & ~ecc_disable;
        assign sec_det[b] = chk[b] & par;
        assign ded_det[b] = chk[b] & ~par & (syn != '0);
        assign cor_d[b]   = raw_d ^ (par ? flip_mask(syn) : '0);
        assign sec_data[b*DATA_WIDTH +: DATA_WIDTH] = sdat_q[b];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sdat_q[b] <= '0;
                addr_q[b] <= '0;
            end else if (chk[b]) begin
                sdat_q[b] <= cor_d[b];
                addr_q[b] <= rd_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // ---------------- scrub write-back queue ----------------
    logic [ADDR_WIDTH-1:0] q_addr [WBQ_DEPTH];
    logic [BW-1:0]         q_bank [WBQ_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [WBQ_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [QW-1:0]         cnt_q, free_slots, acc;
    logic [2:0]            drops;
    logic                  pop;
    logic [NUM_BANKS-1:0]  wr_en;
    logic [PW-1:0]         wr_idx [NUM_BANKS];

    assign wb_valid = (cnt_q != '0);
    assign pop      = wb_valid & wb_ready;

    // Ascending bank order takes free slots first, so overflow drops the highest banks.
    always_comb begin
        free_slots = QW'(WBQ_DEPTH) - cnt_q + QW'(pop);
        acc        = '0;
        drops      = '0;
        wr_en      = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            wr_idx[b] = wptr_q + acc[PW-1:0];
            if (preq_q[b]) begin
                if (acc < free_slots) begin
                    wr_en[b] = 1'b1;
                    acc      = acc + QW'(1);
                end else begin
                    drops = drops + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (wr_en[b]) begin
                q_addr[wr_idx[b]] <= addr_q[b];
                q_bank[wr_idx[b]] <= BW'(b);
                q_data[wr_idx[b]] <= sdat_q[b];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            sec_q    <= '0;
            ded_q    <= '0;
            preq_q   <= '0;
            sec_cnt  <= '0;
            ded_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            wptr_q <= wptr_q + acc[PW-1:0];
            rptr_q <= rptr_q + PW'(pop);
            cnt_q  <= cnt_q + acc - QW'(pop);
            sec_q  <= sec_det;
            ded_q  <= ded_det;
            preq_q <= sec_det & {NUM_BANKS{scrub_en}};
            // Error counters move on the same edge as the flags they count.
            if (cnt_clr) begin
                sec_cnt  <= '0;
                ded_cnt  <= '0;
                drop_cnt <= '0;
            end else begin
                sec_cnt  <= sat_add(sec_cnt, 3'($countones(sec_det)));
                ded_cnt  <= sat_add(ded_cnt, 3'($countones(ded_det)));
                drop_cnt <= sat_add(drop_cnt, drops);
            end
        end
    end

    assign sec_err = sec_q;
    assign ded_err = ded_q;
    assign any_sec = |sec_q;
    assign any_ded = |ded_q;
    // Head fields read as zero when empty so stale slots never reach the arbiter.
    assign wb_addr = wb_valid ? q_addr[rptr_q] : '0;
    assign wb_bank = wb_valid ? q_bank[rptr_q] : '0;
    assign wb_data = wb_valid ? q_data[rptr_q] : '0;
    assign wb_ecc  = hm_encode(wb_data);

endmodule
